// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory loader.
//   IMEM_DEPTH_W : default word-address width of the instruction memory
//   LEN_W        : width of the frame word-count field
//   BYTE_W/WORD_W: stream byte and memory word widths
//   state_e      : loader FSM states
package imem_pkg;

    localparam int unsigned IMEM_DEPTH_W = 5;
    localparam int unsigned LEN_W        = 16;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned WORD_W       = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs four stream bytes (LSB first) into one 32-bit word.
//   clk, rst     : clock, synchronous active-low reset
//   clear        : drop any partial word and restart at byte 0
//   byte_en      : a data byte is transferred this cycle
//   byte_in      : the data byte
//   word_c       : assembled word, valid while word_done_c is high
//   word_done_c  : this byte completes a word
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    localparam int unsigned BUF_W = WORD_W - BYTE_W;

    logic [1:0]       cnt_q, cnt_d;
    logic [BUF_W-1:0] buf_q, buf_d;

    // Store bytes 0..2; byte 3 goes straight to word_c so the word is complete on its accept edge.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear) begin
            cnt_d = '0;
            buf_d = '0;
        end else if (byte_en) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    buf_d[7:0]   = byte_in;
                2'd1:    buf_d[15:8]  = byte_in;
                2'd2:    buf_d[23:16] = byte_in;
                default: buf_d        = buf_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign word_c      = {byte_in, buf_q};
    assign word_done_c = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image from a byte stream into instruction memory and
// releases the core only after the image checksum matches.
//   clk, rst    : clock, synchronous active-low reset
//   start       : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid/in_data/in_ready : byte stream, transfer on valid && ready
//   mem_we/mem_waddr/mem_wdata : one-word-per-cycle memory write port
//   core_rst_n  : core reset, released only in DONE
//   busy/done/error : status
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_W   = IMEM_DEPTH_W,
    parameter int unsigned BASE_WORD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [DEPTH_W-1:0] mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               core_rst_n,
    output logic               busy,
    output logic               done,
    output logic               error
);

    // Largest word count that still fits above BASE_WORD.
    localparam int unsigned MAX_LEN = (32'd1 << DEPTH_W) - BASE_WORD;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic [BYTE_W-1:0]  csum_q, csum_d;
    logic               mem_we_q, mem_we_d;
    logic [DEPTH_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               core_rst_n_q, core_rst_n_d;

    logic               accept_c;
    logic               start_load_c;
    logic               pack_en_c;
    logic [WORD_W-1:0]  word_c;
    logic               word_done_c;

    assign accept_c     = in_valid && active_q;
    assign start_load_c = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign pack_en_c    = accept_c && (state_q == S_DATA);

    imem_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_load_c),
        .byte_en     (pack_en_c),
        .byte_in     (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // Next-state, checksum, address counter and write-port computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_load_c) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    wcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    len_d   = {len_q[15:8], in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept_c) begin
                    len_d = {in_data, len_q[7:0]};
                    if (32'(len_d) > MAX_LEN) begin
                        state_d = S_ERR;
                    end else if (len_d == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    csum_d = csum_q ^ in_data;
                    if (word_done_c) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = DEPTH_W'(BASE_WORD) + DEPTH_W'(wcnt_q);
                        mem_wdata_d = word_c;
                        wcnt_d      = wcnt_q + LEN_W'(1);
                        if (wcnt_d == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they line up with state_q.
        active_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                       (state_d == S_DATA)   || (state_d == S_CSUM);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        core_rst_n_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            wcnt_q       <= '0;
            csum_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            csum_q       <= csum_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            active_q     <= active_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Stream-ready and busy cover the same set of states.
    assign in_ready   = active_q;
    assign busy       = active_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign error      = error_q;
    assign core_rst_n = core_rst_n_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the single-cycle core's instruction memory.
- Receives a framed program image as an 8-bit valid/ready byte stream, for example from a UART receiver or test host.
- Assembles little-endian 32-bit words and drives a one-word-per-cycle write port into instruction memory.
- Holds the core in reset while loading and releases it only after a checksum-verified image has been written.

Parameters:
- DEPTH_W, 5, word-address width; memory holds 2**DEPTH_W words (default 32).
- BASE_WORD, 0, first word index written.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR
- in_valid  input  1  byte available
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
- mem_waddr  output  DEPTH_W  word index; memory byte address = index<<2
- mem_wdata  output  32  assembled word
- core_rst_n  output  1  active-low reset to the core; low while loading
- busy  output  1  high in any state other than IDLE, DONE or ERR
- done  output  1  high in DONE
- error  output  1  high in ERR

Behaviour:
- Frame format:
  - LEN_LO, LEN_HI: word count N, 16-bit little-endian.
  - N×4 data bytes: each word sent LSB first.
  - CSUM: one byte equal to the XOR of all data bytes. Length bytes are excluded.
- A byte transfers when in_valid && in_ready on a rising edge.
- in_ready = 1 only in states S_LEN_LO, S_LEN_HI, S_DATA and S_CSUM.
- Reset (rst=0 at a clock edge), from any state including mid-frame:
  - state=S_IDLE, mem_we=0, mem_waddr=0, mem_wdata=0, byte counter=0, word counter=0, checksum=0.
  - in_ready=0, busy=0, done=0, error=0.
  - core_rst_n=0: the core stays held until a successful load.
- States and transitions:
  - S_IDLE: start → S_LEN_LO. Clears checksum and counters; core_rst_n=0.
  - S_LEN_LO: accept byte → len[7:0]; go to S_LEN_HI.
  - S_LEN_HI: accept byte → len[15:8].
    - If len > 2**DEPTH_W − BASE_WORD → S_ERR.
    - Else if len==0 → S_CSUM.
    - Else → S_DATA.
  - S_DATA: each accepted byte shifts into wdata[8*k +: 8], where k = byte counter 0..3, and XORs into checksum.
    - On k==3: register mem_we=1 for the next cycle only, with mem_waddr = BASE_WORD + word counter and the complete word; increment word counter; reset k to 0.
    - After word N is accepted → S_CSUM.
  - S_CSUM: accept byte. Equal to checksum → S_DONE; otherwise → S_ERR.
  - S_DONE: core_rst_n=1, done=1. start → new load; core_rst_n drops to 0 on the same edge.
  - S_ERR: error=1, core_rst_n=0. start → new load.
- Latency: mem_we asserts exactly 1 cycle after the edge that accepts a word's 4th byte. Write-port values hold until the next write; mem_we is low otherwise.
- A write for the last word and the CSUM byte transfer may occur back-to-back with no bubble. The loader sustains one byte per cycle.
- start while busy is ignored.
- Words already written before an ERR are not rolled back; the core is not released.
- in_valid gaps of any length mid-word preserve the partial word and counters.
- Word address never wraps: the length check guarantees BASE_WORD+N−1 ≤ 2**DEPTH_W−1.
- Reset asserted mid-word discards the partial word; no write is issued.

Decomposition:
- Shared package imem_pkg:
  - state enum (S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR).
  - IMEM_DEPTH_W=5.
  - frame length field width LEN_W=16.
- One natural sub-module, imem_word_packer: byte counter, shift-in of 4 bytes, word-complete strobe.
- The FSM, checksum and address counter remain in imem_loader.

Test Plan:
- Single word: start; bytes 01 00 03 A3 C4 FF, CSUM=03^A3^C4^FF=9B.
  - Expect one mem_we with waddr=0, wdata=FFC4A303.
  - Then done=1 and core_rst_n=1.
- Three words streamed back-to-back with in_valid constant (FFC4A303, 0064A423, 0062E233), correct CSUM.
  - Expect writes at 0,1,2 on consecutive 4-cycle boundaries, then done.
- Same frame with CSUM byte XOR 01.
  - Expect the 3 writes, then error=1, done=0, core_rst_n=0.
- Length 0x0021 with DEPTH_W=5.
  - Expect ERR immediately after LEN_HI, no mem_we, and in_ready=0 afterwards.
- Random in_valid gaps (0–5 cycles) within a 2-word frame.
  - Expect data identical to the no-gap run.
- Reset mid-frame after 6 data bytes, then a fresh 1-word load.
  - Expect only the first word's write before reset.
  - After reset: all outputs at reset values.
  - Second load writes waddr=0 correctly and ends in done.
